// File: rtl/pu_sequencer.sv
// Sequences neuron evaluations through one shared processing unit and feeds the
// results back until they stop changing or the iteration cap is reached.
module pu_sequencer #(
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned PU_LATENCY  = 2,
  parameter int unsigned MAX_ITER    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [31:0]               pu_out,
  output logic                      issue_valid,
  output logic [IDX_W-1:0]          issue_idx,
  output logic                      src_sel,
  output logic [32*NUM_NEURONS-1:0] res_flat,
  output logic [7:0]                iter_cnt,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] ITER_CAP = CNT_W'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [PU_LATENCY-1:0] vld_sr;
  logic [IDX_W-1:0]      idx_sr [PU_LATENCY];
  logic                  changed;

  logic                  cap_valid;
  logic [IDX_W-1:0]      cap_idx;
  logic [DATA_W-1:0]     cap_old;
  logic                  drained;
  logic [CNT_W-1:0]      iter_inc;
  logic                  stop;
  logic                  enter_issue;

  logic                  valid_nx;
  logic [IDX_W-1:0]      idx_nx;
  logic                  src_nx;
  logic [CNT_W-1:0]      iter_cnt_nx;
  logic                  busy_nx;
  logic                  done_nx;

  assign cap_valid   = vld_sr[PU_LATENCY-1];
  assign cap_idx     = idx_sr[PU_LATENCY-1];
  assign drained     = ~|vld_sr;
  assign iter_inc    = iter_cnt + 8'd1;
  // Converged only counts once at least one feedback pass has been compared.
  assign stop        = (iter_inc == ITER_CAP) || (!changed && (iter_inc >= 8'd2));
  assign enter_issue = (state_nx == S_ISSUE) && (state != S_ISSUE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_ISSUE;
      S_ISSUE: if (issue_idx == LAST_IDX) state_nx = S_DRAIN;
      S_DRAIN: if (drained) state_nx = S_CHECK;
      S_CHECK: state_nx = stop ? S_DONE : S_ISSUE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered control outputs
  always_comb begin
    valid_nx    = 1'b0;
    idx_nx      = '0;
    src_nx      = src_sel;
    iter_cnt_nx = iter_cnt;
    busy_nx     = (state_nx != S_IDLE);
    done_nx     = (state_nx == S_DONE);
    case (state)
      S_IDLE: begin
        if (start) begin
          valid_nx    = 1'b1;
          src_nx      = 1'b0;
          iter_cnt_nx = '0;
        end
      end
      S_ISSUE: begin
        if (issue_idx != LAST_IDX) begin
          valid_nx = 1'b1;
          idx_nx   = issue_idx + 1'b1;
        end
      end
      S_CHECK: begin
        iter_cnt_nx = iter_inc;
        if (!stop) begin
          valid_nx = 1'b1;
          src_nx   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Previous contents of the slot about to be captured
  always_comb begin
    cap_old = '0;
    for (int k = 0; k < int'(NUM_NEURONS); k++) begin
      if (cap_idx == IDX_W'(k)) cap_old = res_flat[DATA_W*k +: DATA_W];
    end
  end

  // Output registers, in-flight tracking and result buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid <= 1'b0;
      issue_idx   <= '0;
      src_sel     <= 1'b0;
      iter_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      vld_sr      <= '0;
      for (int i = 0; i < int'(PU_LATENCY); i++) idx_sr[i] <= '0;
      res_flat    <= '0;
      changed     <= 1'b0;
    end else begin
      issue_valid <= valid_nx;
      issue_idx   <= idx_nx;
      src_sel     <= src_nx;
      iter_cnt    <= iter_cnt_nx;
      busy        <= busy_nx;
      done        <= done_nx;

      vld_sr[0] <= issue_valid;
      idx_sr[0] <= issue_idx;
      for (int i = 1; i < int'(PU_LATENCY); i++) begin
        vld_sr[i] <= vld_sr[i-1];
        idx_sr[i] <= idx_sr[i-1];
      end

      if (enter_issue) changed <= 1'b0;
      if (cap_valid) begin
        for (int k = 0; k < int'(NUM_NEURONS); k++) begin
          if (cap_idx == IDX_W'(k)) res_flat[DATA_W*k +: DATA_W] <= pu_out;
        end
        if (pu_out != cap_old) changed <= 1'b1;
      end
    end
  end

  // Issued indices stay in range and the operand source is fixed within a sweep
  a_idx_range: assert property (@(posedge clk) disable iff (rst)
    issue_valid |-> (issue_idx <= LAST_IDX));
  a_src_stable: assert property (@(posedge clk) disable iff (rst)
    (issue_valid && $past(issue_valid)) |-> $stable(src_sel));

endmodule

// File: tb/tb_pu_sequencer.sv
// Directed bench for pu_sequencer with a two-stage PU model on pu_out.
module tb_pu_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  pu_out;
  logic         issue_valid;
  logic [1:0]   issue_idx;
  logic         src_sel;
  logic [127:0] res_flat;
  logic [7:0]   iter_cnt;
  logic         busy;
  logic         done;

  int tests  = 0;
  int failed = 0;

  // PU model: mode 0 returns 0x10+idx, mode 1 returns the free-running cycle count
  logic        mode = 1'b0;
  logic [31:0] cyc  = 32'd0;
  logic [31:0] p1, p2;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 32'd1;
    p1  <= mode ? cyc : (32'h10 + {30'd0, issue_idx});
    p2  <= p1;
  end
  assign pu_out = p2;

  pu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .pu_out(pu_out),
    .issue_valid(issue_valid), .issue_idx(issue_idx), .src_sel(src_sel),
    .res_flat(res_flat), .iter_cnt(iter_cnt), .busy(busy), .done(done)
  );

  localparam logic [127:0] BASIC_RES = {32'h13, 32'h12, 32'h11, 32'h10};

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done: got %0b want 0", done); end
    tests++; if (issue_valid !== 1'b0) begin failed++; $display("FAIL reset_issue_valid: got %0b want 0", issue_valid); end
    tests++; if (issue_idx !== 2'd0) begin failed++; $display("FAIL reset_issue_idx: got %0d want 0", issue_idx); end
    tests++; if (src_sel !== 1'b0) begin failed++; $display("FAIL reset_src_sel: got %0b want 0", src_sel); end
    tests++; if (res_flat !== 128'd0) begin failed++; $display("FAIL reset_res_flat: got %h want 0", res_flat); end
    tests++; if (iter_cnt !== 8'd0) begin failed++; $display("FAIL reset_iter_cnt: got %0d want 0", iter_cnt); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int done_at = -1;
    int done_n  = 0;
    int seq_bad = 0;
    logic [7:0] done_iter = 8'hff;
    logic busy_after = 1'b1;
    mode = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c <= 4 && (issue_valid !== 1'b1 || issue_idx !== 2'(c - 1))) seq_bad++;
      if (c == 5 && issue_valid !== 1'b0) seq_bad++;
      if (done === 1'b1) begin
        done_n++;
        if (done_at < 0) begin done_at = c; done_iter = iter_cnt; end
      end
      if (done_at > 0 && c == done_at + 1) busy_after = busy;
    end
    tests++; if (seq_bad !== 0) begin failed++; $display("FAIL basic_issue_seq: %0d bad cycles want 0", seq_bad); end
    tests++; if (done_at !== 17) begin failed++; $display("FAIL basic_done_cycle: got %0d want 17", done_at); end
    tests++; if (done_n !== 1) begin failed++; $display("FAIL basic_done_pulses: got %0d want 1", done_n); end
    tests++; if (done_iter !== 8'd2) begin failed++; $display("FAIL basic_iter_cnt: got %0d want 2", done_iter); end
    tests++; if (busy_after !== 1'b0) begin failed++; $display("FAIL basic_busy_after_done: got %0b want 0", busy_after); end
    tests++; if (res_flat !== BASIC_RES) begin failed++; $display("FAIL basic_res_flat: got %h want %h", res_flat, BASIC_RES); end
  endtask

  task automatic test_capture_timing();
    logic [31:0]  s0 = '0;
    logic [31:0]  exp_val = '0;
    logic [127:0] snap = '0;
    int done_at = -1;
    mode = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 120 && done_at < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 3) begin
        tests++; if (issue_valid !== 1'b1 || issue_idx !== 2'd2) begin
          failed++; $display("FAIL cap_issue2: got valid=%0b idx=%0d want valid=1 idx=2", issue_valid, issue_idx);
        end
        s0 = res_flat[95:64];
        exp_val = cyc;
      end
      if (c == 5) begin
        tests++; if (res_flat[95:64] !== s0) begin failed++; $display("FAIL cap_early_t1: got %h want %h", res_flat[95:64], s0); end
      end
      if (c == 6) begin
        tests++; if (res_flat[95:64] !== exp_val) begin failed++; $display("FAIL cap_at_t2: got %h want %h", res_flat[95:64], exp_val); end
      end
      if (c == 8) snap = res_flat;
      if (c == 9) begin
        tests++; if (res_flat !== snap) begin failed++; $display("FAIL cap_during_check: got %h want %h", res_flat, snap); end
      end
      if (done === 1'b1) done_at = c;
    end
    tests++; if (done_at < 0) begin failed++; $display("FAIL cap_run_timeout: got no done want done"); end
    @(negedge clk);
  endtask

  task automatic test_nonconverge();
    int iters = 0;
    int src_bad = 0;
    int done_at = -1;
    logic prev_valid = 1'b0;
    logic [7:0] done_iter = 8'hff;
    mode = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 120 && done_at < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (issue_valid === 1'b1 && !prev_valid) begin
        iters++;
        if (src_sel !== ((iters == 1) ? 1'b0 : 1'b1)) src_bad++;
      end
      prev_valid = issue_valid;
      if (done === 1'b1) begin done_at = c; done_iter = iter_cnt; end
    end
    tests++; if (done_at !== 65) begin failed++; $display("FAIL nc_done_cycle: got %0d want 65", done_at); end
    tests++; if (iters !== 8) begin failed++; $display("FAIL nc_iterations: got %0d want 8", iters); end
    tests++; if (src_bad !== 0) begin failed++; $display("FAIL nc_src_sel: %0d bad iterations want 0", src_bad); end
    tests++; if (done_iter !== 8'd8) begin failed++; $display("FAIL nc_iter_cnt: got %0d want 8", done_iter); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dirty = 0;
    mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL rmid_busy: got %0b want 0", busy); end
    tests++; if (issue_valid !== 1'b0) begin failed++; $display("FAIL rmid_issue_valid: got %0b want 0", issue_valid); end
    tests++; if (res_flat !== 128'd0) begin failed++; $display("FAIL rmid_res_flat: got %h want 0", res_flat); end
    tests++; if (iter_cnt !== 8'd0) begin failed++; $display("FAIL rmid_iter_cnt: got %0d want 0", iter_cnt); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (res_flat !== 128'd0 || busy !== 1'b0) dirty++;
    end
    tests++; if (dirty !== 0) begin failed++; $display("FAIL rmid_inflight_write: %0d dirty cycles want 0", dirty); end
  endtask

  task automatic test_ignored_start();
    int done_at = -1;
    int done_n = 0;
    logic [7:0] done_iter = 8'hff;
    mode = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = (c == 5 || c == 17 || c == 19) ? 1'b1 : 1'b0;
      if (done === 1'b1) begin
        done_n++;
        if (done_at < 0) begin done_at = c; done_iter = iter_cnt; end
      end
      if (c == 18) begin
        tests++; if (busy !== 1'b0 || issue_valid !== 1'b0) begin
          failed++; $display("FAIL ign_no_restart: got busy=%0b valid=%0b want 0 0", busy, issue_valid);
        end
      end
      if (c == 20) begin
        tests++; if (issue_valid !== 1'b1 || issue_idx !== 2'd0 || src_sel !== 1'b0 || iter_cnt !== 8'd0) begin
          failed++; $display("FAIL ign_new_run: got valid=%0b idx=%0d src=%0b iter=%0d want 1 0 0 0",
                             issue_valid, issue_idx, src_sel, iter_cnt);
        end
      end
    end
    tests++; if (done_at !== 17) begin failed++; $display("FAIL ign_done_cycle: got %0d want 17", done_at); end
    tests++; if (done_n !== 1) begin failed++; $display("FAIL ign_done_pulses: got %0d want 1", done_n); end
    tests++; if (done_iter !== 8'd2) begin failed++; $display("FAIL ign_iter_cnt: got %0d want 2", done_iter); end
    done_at = -1;
    done_iter = 8'hff;
    for (int c = 21; c <= 80 && done_at < 0; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin done_at = c; done_iter = iter_cnt; end
    end
    tests++; if (done_at !== 36) begin failed++; $display("FAIL ign_second_done: got %0d want 36", done_at); end
    tests++; if (done_iter !== 8'd2) begin failed++; $display("FAIL ign_second_iter: got %0d want 2", done_iter); end
    tests++; if (res_flat !== BASIC_RES) begin failed++; $display("FAIL ign_res_flat: got %h want %h", res_flat, BASIC_RES); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_basic();
    test_capture_timing();
    test_nonconverge();
    test_reset_mid();
    test_ignored_start();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
